// File: rtl/aes_key_sched_iter.sv
// AES S-box: combinational 256-entry FIPS-197 substitution table.
// Latency: 0 cycles (pure lookup).
// Backpressure: none, combinational.
// Ports: a = input byte, y = substituted byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Entry 0 sits in the most significant byte, so entry b lives at
    // byte offset (255 - b) from the LSB, which is simply ~b.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

// AES-128 iterative key schedule: emits round keys 0..ROUNDS, one per transfer.
// Latency: first key valid 1 cycle after an accepted start; then 1 key per cycle.
// Backpressure: rk/rk_round/rk_last hold while rk_valid=1 and rk_ready=0.
// Ports: clk, rst (async active-low); start/key/ready = schedule request;
//        rk_valid/rk_ready/rk/rk_round/rk_last = round key stream.
module aes_key_sched_iter #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]   rcon;
    logic         is_last;
    logic         accept;
    logic         advance;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t;
    logic [31:0]  w0_n;
    logic [31:0]  w1_n;
    logic [31:0]  w2_n;
    logic [31:0]  w3_n;
    logic [127:0] rk_next;
    logic [7:0]   rcon_next;

    assign is_last = (rk_round == LAST_ROUND);
    assign accept  = (state_q == S_IDLE) && start;
    // Only non-final transfers step the key; the final one just returns to IDLE
    // so rk and rk_round keep showing the last key.
    assign advance = (state_q == S_RUN) && rk_ready && !is_last;

    // Expansion step: rotate w3 left one byte, substitute, fold in rcon,
    // then ripple the XOR through the four words.
    assign rot_w3 = {rk[23:0], rk[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_w3[8*i +: 8]),
            .y (sub_w3[8*i +: 8])
        );
    end

    assign t       = sub_w3 ^ {rcon, 24'h0};
    assign w0_n    = rk[127:96] ^ t;
    assign w1_n    = rk[95:64]  ^ w0_n;
    assign w2_n    = rk[63:32]  ^ w1_n;
    assign w3_n    = rk[31:0]   ^ w2_n;
    assign rk_next = {w0_n, w1_n, w2_n, w3_n};

    // Doubling in GF(2^8) with the AES reduction polynomial.
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start while running is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (rk_ready && is_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ready    = (state_q == S_IDLE);
        rk_valid = (state_q == S_RUN);
        rk_last  = (state_q == S_RUN) && is_last;
    end

    // Round key datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk       <= '0;
            rk_round <= '0;
            rcon     <= 8'h01;
        end else if (accept) begin
            rk       <= key;
            rk_round <= '0;
            rcon     <= 8'h01;
        end else if (advance) begin
            rk       <= rk_next;
            rk_round <= rk_round + 4'd1;
            rcon     <= rcon_next;
        end
    end
endmodule

// File: tb/tb_aes_key_sched_iter.sv
module tb_aes_key_sched_iter;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;

    logic         start3;
    logic         ready3;
    logic         rk_valid3;
    logic         rk_ready3;
    logic [127:0] rk3;
    logic [3:0]   rk_round3;
    logic         rk_last3;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sb  [256];
    logic [127:0] mdl [11];
    logic [127:0] cap [11];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_key_sched_iter #(.ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .ready(ready),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
        .rk_round(rk_round), .rk_last(rk_last)
    );

    aes_key_sched_iter #(.ROUNDS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .key(key), .ready(ready3),
        .rk_valid(rk_valid3), .rk_ready(rk_ready3), .rk(rk3),
        .rk_round(rk_round3), .rk_last(rk_last3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box derived from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] x;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (b != 0 && gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            x = inv;
            sb[b] = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                      ^ {x[3:0], x[7:4]} ^ 8'h63;
        end
    endtask

    // Textbook word-array key expansion (44 words).
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rcon_tab[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Runs one schedule on the ROUNDS=10 instance; called and returns at a negedge.
    task automatic sched(input logic [127:0] k, input bit rnd, input bit stall,
                         input bit ign, input bit abort);
        int  er, nvalid, nstall, scnt;
        bit  done;
        expand(k);
        chk("ready_idle", ready, 1);
        key = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = {$urandom, $urandom, $urandom, $urandom};
        er = 0; nvalid = 0; nstall = 0; scnt = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            chk("valid_run", rk_valid, 1);
            chk("ready_run", ready, 0);
            if (rk_valid) nvalid++;
            chk($sformatf("rk_r%0d", er), rk, mdl[er]);
            chk("rk_round", rk_round, er);
            chk("rk_last", rk_last, er == 10);
            cap[er] = rk;
            if (abort && er == 6) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_valid", rk_valid, 0);
                chk("abort_ready", ready, 1);
                chk("abort_rk", rk, 0);
                chk("abort_round", rk_round, 0);
                chk("abort_last", rk_last, 0);
                @(negedge clk);
                rst = 1'b1;
                rk_ready = 1'b1;
                return;
            end
            start = 1'b0;
            if (ign && er == 2) begin
                start = 1'b1;
                key = ~k;
            end
            if (stall && er == 4 && scnt < 3) begin
                rk_ready = 1'b0; scnt++; nstall++;
            end else if (rnd) begin
                rk_ready = 1'($urandom_range(0, 1));
                if (!rk_ready) nstall++;
            end else begin
                rk_ready = 1'b1;
            end
            if (rk_ready) begin
                if (er == 10) done = 1;
                else er++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("sched_done", done, 1);
        chk("n_valid", nvalid, 11 + nstall);
        chk("post_ready", ready, 1);
        chk("post_valid", rk_valid, 0);
        chk("post_rk", rk, mdl[10]);
        chk("post_round", rk_round, 10);
        chk("post_last", rk_last, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start3 = 1'b0; key = '0;
        rk_ready = 1'b1; rk_ready3 = 1'b1;
        build_sbox();
        #3;
        chk("rst_ready", ready, 1);
        chk("rst_valid", rk_valid, 0);
        chk("rst_rk", rk, 0);
        chk("rst_round", rk_round, 0);
        chk("rst_last", rk_last, 0);
        chk("rst_ready3", ready3, 1);
        chk("rst_valid3", rk_valid3, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Known-answer schedule, full throughput.
        sched(FIPS_KEY, 0, 0, 0, 0);
        chk("fips_r0", cap[0], FIPS_KEY);
        chk("fips_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero key, back-to-back with the previous schedule.
        sched(128'h0, 0, 0, 0, 0);
        chk("zero_r1", cap[1], 128'h62636363626363636263636362636363);
        chk("zero_r10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Backpressure for three cycles at round 4.
        sched(FIPS_KEY, 0, 1, 0, 0);
        chk("stall_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Start with a different key during the run must be ignored.
        sched(FIPS_KEY, 0, 0, 1, 0);
        chk("ign_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Asynchronous reset mid-schedule, then a fresh schedule.
        sched(FIPS_KEY, 0, 0, 0, 1);
        sched(FIPS_KEY, 0, 0, 0, 0);
        chk("after_abort_r0", cap[0], FIPS_KEY);

        // Random keys with random consumer backpressure.
        for (int n = 0; n < 6; n++)
            sched({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 0);

        // Short schedule on the ROUNDS=3 instance.
        expand(FIPS_KEY);
        rk_ready3 = 1'b1;
        chk("r3_ready", ready3, 1);
        key = FIPS_KEY; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk("r3_valid", rk_valid3, 1);
            chk($sformatf("r3_rk%0d", r), rk3, mdl[r]);
            chk("r3_round", rk_round3, r);
            chk("r3_last", rk_last3, r == 3);
            @(negedge clk);
        end
        chk("r3_final_key", rk3, 128'h3d80477d4716fe3e1e237e446d7a883b);
        chk("r3_post_ready", ready3, 1);
        chk("r3_post_valid", rk_valid3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes_key_sched_iter.md
Name: aes_key_sched_iter

Overview:
- Iterative AES-128 key schedule that sits directly upstream of the AES round datapath.
- Accepts a 128-bit cipher key on a start handshake.
- Emits round keys 0..ROUNDS one per accepted beat on a valid/ready stream. The round datapath consumes one key per round.
- Computes one FIPS-197 expansion step per transfer using four internal S-box lookups. No key storage beyond the current round key.

Parameters:
- ROUNDS, 10, index of the last round key emitted. Legal range 1..10; 10 gives full AES-128.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. 0 = reset asserted.
- start  input  1  request to begin a schedule. Sampled only when ready=1.
- key  input  128  cipher key, sampled on an accepted start. key[127:96] = w0, key[31:0] = w3.
- ready  output  1  block idle and able to accept start.
- rk_valid  output  1  rk/rk_round/rk_last hold a valid round key.
- rk_ready  input  1  consumer accepts the current round key.
- rk  output  128  current round key, same word order as key.
- rk_round  output  4  index of the current round key, 0..ROUNDS.
- rk_last  output  1  high while rk_round == ROUNDS and rk_valid=1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, rk_valid=0, rk=0, rk_round=0, rk_last=0, rcon=8'h01. All outputs take these values immediately, without a clock edge. Release is synchronous to clk.
- States:
  - IDLE: ready=1, rk_valid=0.
  - RUN: ready=0, rk_valid=1.
- IDLE -> RUN when start=1 at a rising edge. On that edge: rk <= key, rk_round <= 0, rcon <= 8'h01. The first key is valid the cycle after start is accepted (latency 1).
- In RUN, a transfer occurs on a rising edge with rk_valid & rk_ready:
  - If rk_round < ROUNDS: rk <= next(rk), rk_round <= rk_round+1, rcon <= xtime(rcon). Stay in RUN.
  - If rk_round == ROUNDS: go to IDLE. rk_valid=0 and ready=1 on the next cycle; rk and rk_round hold their last values.
- next(rk):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the AES S-box to each byte.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - Rcon sequence used for rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
- Backpressure: while rk_valid=1 and rk_ready=0, rk, rk_round and rk_last hold stable. No bubbles when rk_ready stays high: a full schedule is ROUNDS+1 consecutive valid cycles.
- start while in RUN is ignored; key is not sampled.
- Back-to-back: a start presented in the first IDLE cycle after the last transfer is accepted. Minimum gap between schedules is 1 cycle.
- rst asserted mid-schedule aborts the schedule immediately, with all outputs at reset values. The next schedule requires a fresh start.
- S-box: combinational 256-entry FIPS-197 table inside the block, four instances (one per byte). The critical path is S-box plus XOR chain, in one cycle.
- All arithmetic is bitwise XOR on fixed widths; there is no carry or overflow anywhere.

Test Plan:
- Reset then start with key=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1:
  - Round 0 is the key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1.
  - ready=1 one cycle later. Exactly 11 valid cycles.
- start with key=0, rk_ready=1:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: drop rk_ready for 3 cycles at rk_round=4 -> rk and rk_round=4 hold unchanged. The round 5 key appears one cycle after rk_ready returns. Final keys match the first scenario.
- start asserted with a different key during RUN at rk_round=2 -> ignored, and the sequence continues to the first scenario's round 10 value.
- rst=0 asserted between clock edges at rk_round=6 -> rk_valid=0, ready=1, rk=0 without waiting for an edge. A subsequent start yields round 0 again.
- ROUNDS=3 build -> 4 valid beats, rk_last on rk_round=3 with value 3d80477d4716fe3e1e237e446d7a883b.
